// File: rtl/adc_seq_ctrl.sv
// rtl/adc_seq_ctrl.sv - parallel ADC sequencer: power-up, CONVST, EOC wait/timeout, RD capture, sample stream
// Build macro ADC_AVG_EN: present the mean of 2^AVG_LOG2 captures instead of every capture.
module adc_seq_ctrl #(
  parameter int DW          = 8,
  parameter int PWRUP_CYC   = 1000,
  parameter int CONVST_LOW  = 2,
  parameter int RD_SETUP    = 2,
  parameter int RD_LOW      = 6,
  parameter int RECOVER_CYC = 7,
  parameter int EOC_TIMEOUT = 255,
  parameter int DIV_W       = 16,
  parameter int AVG_LOG2    = 2
) (
  input  logic             clk_100M,
  input  logic             Reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] sample_div,
  input  logic             clr_err,
  input  logic             EOC_18,
  input  logic [DW-1:0]    DB_in,
  output logic             CONVST_18,
  output logic             RD_18,
  output logic             PD_18,
  output logic [DW-1:0]    sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  if (RD_LOW <= RD_SETUP || RD_SETUP < 1 || AVG_LOG2 < 1) begin : g_param_check
    $error("adc_seq_ctrl: RD_LOW must exceed RD_SETUP >= 1 and AVG_LOG2 must be >= 1");
  end

  localparam int CMAX1 = (PWRUP_CYC > EOC_TIMEOUT) ? PWRUP_CYC : EOC_TIMEOUT;
  localparam int CMAX2 = (RD_LOW > RECOVER_CYC) ? RD_LOW : RECOVER_CYC;
  localparam int CMAX3 = (CONVST_LOW > CMAX2) ? CONVST_LOW : CMAX2;
  localparam int CMAX  = (CMAX1 > CMAX3) ? CMAX1 : CMAX3;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] PWRUP_END = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] CONV_END  = CW'(CONVST_LOW - 1);
  localparam logic [CW-1:0] EOC_END   = CW'(EOC_TIMEOUT - 1);
  localparam logic [CW-1:0] CAP_AT    = CW'(RD_SETUP - 1);
  localparam logic [CW-1:0] RD_END    = CW'(RD_LOW - 1);
  localparam logic [CW-1:0] REC_END   = CW'(RECOVER_CYC - 1);

  typedef enum logic [2:0] {PWRUP, IDLE, CONV, WAIT_EOC, RD_ACT, RECOVER} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             eoc_s1, eoc_s2, eoc_s3, eoc_fall;
  logic [DIV_W-1:0] div_cnt, div_reload;
  logic             tick, pending;
  logic             capture, timeout_hit, present;
  logic [DW-1:0]    present_data;

  // EOC_18 is asynchronous to clk_100M; only the third stage is used for edge history.
  always_ff @(posedge clk_100M) begin
    if (Reset) begin
      eoc_s1 <= 1'b1;
      eoc_s2 <= 1'b1;
      eoc_s3 <= 1'b1;
    end else begin
      eoc_s1 <= EOC_18;
      eoc_s2 <= eoc_s1;
      eoc_s3 <= eoc_s2;
    end
  end
  assign eoc_fall = eoc_s3 & ~eoc_s2;

  assign div_reload = (sample_div == '0) ? '0 : sample_div - 1'b1;
  assign tick       = enable && (div_cnt == '0);

  // A tick arriving while one is already pending (even in the consuming cycle) is dropped.
  always_ff @(posedge clk_100M) begin
    if (Reset || !enable) begin
      div_cnt <= '0;
      pending <= 1'b0;
    end else begin
      div_cnt <= tick ? div_reload : div_cnt - 1'b1;
      if (state == IDLE && pending) pending <= 1'b0;
      else if (tick)                pending <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt + 1'b1;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      PWRUP:    if (cnt == PWRUP_END) begin state_next = IDLE; cnt_next = '0; end
      IDLE: begin
        cnt_next = '0;
        if (pending) state_next = CONV;
      end
      CONV:     if (cnt == CONV_END) begin state_next = WAIT_EOC; cnt_next = '0; end
      WAIT_EOC: begin
        if (eoc_fall) begin
          state_next = RD_ACT;
          cnt_next   = '0;
        end else if (cnt == EOC_END) begin
          state_next  = RECOVER;
          cnt_next    = '0;
          timeout_hit = 1'b1;
        end
      end
      RD_ACT: begin
        capture = (cnt == CAP_AT);
        if (cnt == RD_END) begin state_next = RECOVER; cnt_next = '0; end
      end
      RECOVER:  if (cnt == REC_END) begin state_next = IDLE; cnt_next = '0; end
      default: begin state_next = PWRUP; cnt_next = '0; end
    endcase
    if (!enable) begin
      state_next  = PWRUP;
      cnt_next    = '0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  // Pins are registered from the next state so the ADC never sees decode glitches.
  always_ff @(posedge clk_100M) begin
    if (Reset) begin
      state     <= PWRUP;
      cnt       <= '0;
      CONVST_18 <= 1'b1;
      RD_18     <= 1'b1;
      PD_18     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      CONVST_18 <= (state_next != CONV);
      RD_18     <= (state_next != RD_ACT);
      PD_18     <= enable;
      busy      <= (state_next != IDLE);
    end
  end

`ifdef ADC_AVG_EN
  localparam int AW = DW + AVG_LOG2;
  logic [AW-1:0]       acc, acc_sum;
  logic [AVG_LOG2-1:0] acc_n;

  assign acc_sum = acc + AW'(DB_in);

  always_ff @(posedge clk_100M) begin
    if (Reset || !enable || timeout_hit) begin
      acc   <= '0;
      acc_n <= '0;
    end else if (capture) begin
      acc   <= (acc_n == '1) ? '0 : acc_sum;
      acc_n <= acc_n + 1'b1;
    end
  end
  assign present      = capture && (acc_n == '1);
  assign present_data = acc_sum[AW-1:AVG_LOG2];
`else
  assign present      = capture;
  assign present_data = DB_in;
`endif

  // Set events win over clr_err; a capture during an accepting handshake is not an overrun.
  always_ff @(posedge clk_100M) begin
    if (Reset) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (present) begin
        sample_data  <= present_data;
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (present && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (clr_err)                             overrun <= 1'b0;
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule
